// File: rtl/xif_offload_initiator_if.sv
// Core-side CORE-V-XIF offload bundle: core instruction port, issue/commit/result
// channels and integer register-file writeback, seen from the initiator (master).
interface xif_offload_initiator_if #(
    parameter int X_ID_WIDTH      = 4,
    parameter int XLEN            = 32,
    parameter int MAX_OUTSTANDING = 4
);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic                  instr_valid;
    logic                  instr_ready;
    logic [31:0]           instr;
    logic [XLEN-1:0]       rs1;
    logic [XLEN-1:0]       rs2;

    logic                  issue_valid;
    logic                  issue_ready;
    logic [31:0]           issue_instr;
    logic [X_ID_WIDTH-1:0] issue_id;
    logic [XLEN-1:0]       issue_rs0;
    logic [XLEN-1:0]       issue_rs1;
    logic                  issue_resp_accept;
    logic                  issue_resp_writeback;

    logic                  commit_valid;
    logic [X_ID_WIDTH-1:0] commit_id;
    logic                  commit_kill;

    logic                  result_valid;
    logic                  result_ready;
    logic [X_ID_WIDTH-1:0] result_id;
    logic [XLEN-1:0]       result_data;
    logic [4:0]            result_rd;
    logic                  result_we;

    logic                  wb_stall;
    logic                  xreg_we;
    logic [4:0]            xreg_waddr;
    logic [XLEN-1:0]       xreg_wdata;

    logic                  offload_done;
    logic                  offload_rejected;
    logic [CNT_W-1:0]      outstanding;
    logic                  protocol_err;

    modport master (
        input  instr_valid, instr, rs1, rs2,
        input  issue_ready, issue_resp_accept, issue_resp_writeback,
        input  result_valid, result_id, result_data, result_rd, result_we,
        input  wb_stall,
        output instr_ready,
        output issue_valid, issue_instr, issue_id, issue_rs0, issue_rs1,
        output commit_valid, commit_id, commit_kill,
        output result_ready,
        output xreg_we, xreg_waddr, xreg_wdata,
        output offload_done, offload_rejected, outstanding, protocol_err
    );

    modport slave (
        output instr_valid, instr, rs1, rs2,
        output issue_ready, issue_resp_accept, issue_resp_writeback,
        output result_valid, result_id, result_data, result_rd, result_we,
        output wb_stall,
        input  instr_ready,
        input  issue_valid, issue_instr, issue_id, issue_rs0, issue_rs1,
        input  commit_valid, commit_id, commit_kill,
        input  result_ready,
        input  xreg_we, xreg_waddr, xreg_wdata,
        input  offload_done, offload_rejected, outstanding, protocol_err
    );
endinterface

// File: rtl/xif_offload_initiator.sv
// XIF offload initiator: issues core instructions with fresh IDs, commits them,
// tracks accepted IDs in a bitmap and writes returned results to the integer RF.
//
// state  | meaning
// IDLE   | waiting for a core instruction and a free ID
// ISSUE  | issue_valid held with stable payload until issue_ready
// COMMIT | single-cycle commit (kill on reject), then back to IDLE
module xif_offload_initiator #(
    parameter int X_ID_WIDTH      = 4,
    parameter int XLEN            = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic ck,
    input  logic rst,
    xif_offload_initiator_if.master bus
);
    localparam int NUM_IDS = 2 ** X_ID_WIDTH;
    localparam int CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {IDLE, ISSUE, COMMIT} state_t;

    state_t                state_q, state_d;
    logic [X_ID_WIDTH-1:0] next_id_q;
    logic [NUM_IDS-1:0]    bitmap_q, bitmap_d;
    logic [CNT_W-1:0]      outstanding_q, outstanding_d;
    logic                  err_q;
    logic                  accept_q;
    logic [31:0]           instr_q;
    logic [XLEN-1:0]       rs0_q, rs1_q;
    logic [X_ID_WIDTH-1:0] id_q;
    logic                  xreg_we_q;
    logic [4:0]            xreg_waddr_q;
    logic [XLEN-1:0]       xreg_wdata_q;

    logic instr_ready_c, take, issue_hs, commit_acc, res_hs, res_hit, res_bad;

    always_comb begin
        state_d       = state_q;
        instr_ready_c = 1'b0;
        take          = 1'b0;
        issue_hs      = 1'b0;
        commit_acc    = 1'b0;
        case (state_q)
            IDLE: begin
                instr_ready_c = (outstanding_q < MAX_CNT) && !bitmap_q[next_id_q];
                take          = bus.instr_valid && instr_ready_c;
                if (take) state_d = ISSUE;
            end
            ISSUE: begin
                issue_hs = bus.issue_ready;
                if (issue_hs) state_d = COMMIT;
            end
            COMMIT: begin
                commit_acc = accept_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A result for the ID committing this cycle is still untracked here.
    always_comb begin
        res_hs  = bus.result_valid && !bus.wb_stall;
        res_hit = res_hs && bitmap_q[bus.result_id];
        res_bad = res_hs && !bitmap_q[bus.result_id];

        bitmap_d = bitmap_q;
        if (commit_acc) bitmap_d[id_q] = 1'b1;
        if (res_hit)    bitmap_d[bus.result_id] = 1'b0;

        outstanding_d = outstanding_q;
        case ({commit_acc, res_hit})
            2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
            2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            next_id_q     <= '0;
            bitmap_q      <= '0;
            outstanding_q <= '0;
            err_q         <= 1'b0;
            accept_q      <= 1'b0;
            instr_q       <= '0;
            rs0_q         <= '0;
            rs1_q         <= '0;
            id_q          <= '0;
            xreg_we_q     <= 1'b0;
            xreg_waddr_q  <= '0;
            xreg_wdata_q  <= '0;
        end else begin
            state_q       <= state_d;
            bitmap_q      <= bitmap_d;
            outstanding_q <= outstanding_d;
            if (take) begin
                instr_q <= bus.instr;
                rs0_q   <= bus.rs1;
                rs1_q   <= bus.rs2;
                id_q    <= next_id_q;
            end
            if (issue_hs) begin
                accept_q  <= bus.issue_resp_accept;
                next_id_q <= next_id_q + X_ID_WIDTH'(1);
            end
            if (res_bad) err_q <= 1'b1;
            xreg_we_q <= res_hit && bus.result_we;
            if (res_hit && bus.result_we) begin
                xreg_waddr_q <= bus.result_rd;
                xreg_wdata_q <= bus.result_data;
            end
        end
    end

    // Handshake readies are held low while reset is asserted.
    assign bus.instr_ready      = !rst && instr_ready_c;
    assign bus.result_ready     = !rst && !bus.wb_stall;
    assign bus.issue_valid      = (state_q == ISSUE);
    assign bus.issue_instr      = instr_q;
    assign bus.issue_id         = id_q;
    assign bus.issue_rs0        = rs0_q;
    assign bus.issue_rs1        = rs1_q;
    assign bus.commit_valid     = (state_q == COMMIT);
    assign bus.commit_id        = (state_q == COMMIT) ? id_q : '0;
    assign bus.commit_kill      = (state_q == COMMIT) && !accept_q;
    assign bus.offload_done     = (state_q == COMMIT) && accept_q;
    assign bus.offload_rejected = (state_q == COMMIT) && !accept_q;
    assign bus.xreg_we          = xreg_we_q;
    assign bus.xreg_waddr       = xreg_waddr_q;
    assign bus.xreg_wdata       = xreg_wdata_q;
    assign bus.outstanding      = outstanding_q;
    assign bus.protocol_err     = err_q;
endmodule

// File: tb/tb_xif_offload_initiator.sv
// Bench for xif_offload_initiator: table-driven issue sequence, directed result,
// error and reset cases, then random traffic against an ID-set reference model.
module tb_xif_offload_initiator;
    logic ck;
    logic rst;
    int   checks;
    int   failures;

    xif_offload_initiator_if #(.X_ID_WIDTH(4), .XLEN(32), .MAX_OUTSTANDING(4)) intf ();

    xif_offload_initiator #(.X_ID_WIDTH(4), .XLEN(32), .MAX_OUTSTANDING(4)) dut (
        .ck  (ck),
        .rst (rst),
        .bus (intf.master)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    // Reference model: set of tracked IDs, next ID to hand out, sticky error.
    bit tracked [16];
    int m_next;
    bit m_err;

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < 16; i++) n += tracked[i];
        return n;
    endfunction

    function automatic bit m_ready();
        return (m_count() < 4) && !tracked[m_next];
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 16; i++) tracked[i] = 1'b0;
        m_next = 0;
        m_err  = 1'b0;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic do_issue(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                            input bit acc, input int stall, input int exp_id,
                            input bit exp_kill, input int exp_out, input string tag);
        intf.instr_valid = 1'b1;
        intf.instr       = ins;
        intf.rs1         = a;
        intf.rs2         = b;
        intf.issue_ready = 1'b0;
        #1;
        chk({tag, " instr_ready"}, intf.instr_ready, 1);
        tick();
        intf.instr_valid = 1'b0;
        intf.instr       = ~ins;
        intf.rs1         = ~a;
        intf.rs2         = ~b;
        chk({tag, " issue_valid"}, intf.issue_valid, 1);
        chk({tag, " issue_id"}, intf.issue_id, exp_id);
        chk({tag, " issue_instr"}, intf.issue_instr, ins);
        chk({tag, " issue_rs0"}, intf.issue_rs0, a);
        chk({tag, " issue_rs1"}, intf.issue_rs1, b);
        for (int i = 0; i < stall; i++) begin
            tick();
            chk({tag, " stall payload"}, {intf.issue_valid, intf.commit_valid, intf.issue_id,
                 intf.issue_instr}, {1'b1, 1'b0, 4'(exp_id), ins});
            chk({tag, " stall rs"}, {intf.issue_rs0, intf.issue_rs1}, {a, b});
        end
        intf.issue_ready          = 1'b1;
        intf.issue_resp_accept    = acc;
        intf.issue_resp_writeback = acc;
        tick();
        intf.issue_ready       = 1'b0;
        intf.issue_resp_accept = ~acc;
        chk({tag, " commit_valid"}, intf.commit_valid, 1);
        chk({tag, " commit_id"}, intf.commit_id, exp_id);
        chk({tag, " commit_kill"}, intf.commit_kill, exp_kill);
        chk({tag, " done/rejected"}, {intf.offload_done, intf.offload_rejected},
            {!exp_kill, exp_kill});
        chk({tag, " issue_valid low"}, intf.issue_valid, 0);
        tick();
        chk({tag, " pulses cleared"}, {intf.commit_valid, intf.offload_done,
             intf.offload_rejected}, 0);
        chk({tag, " outstanding"}, intf.outstanding, exp_out);
    endtask

    task automatic send_result(input int id, input bit we, input logic [4:0] rd,
                               input logic [31:0] data, input bit stall, input string tag);
        bit exp_we;
        intf.result_valid = 1'b1;
        intf.result_id    = 4'(id);
        intf.result_we    = we;
        intf.result_rd    = rd;
        intf.result_data  = data;
        intf.wb_stall     = stall;
        #1;
        chk({tag, " result_ready"}, intf.result_ready, !stall);
        exp_we = 1'b0;
        if (!stall) begin
            if (tracked[id]) begin
                tracked[id] = 1'b0;
                exp_we = we;
            end else begin
                m_err = 1'b1;
            end
        end
        tick();
        intf.result_valid = 1'b0;
        intf.wb_stall     = 1'b0;
        chk({tag, " xreg_we"}, intf.xreg_we, exp_we);
        if (exp_we) chk({tag, " xreg addr/data"}, {intf.xreg_waddr, intf.xreg_wdata}, {rd, data});
        chk({tag, " protocol_err"}, intf.protocol_err, m_err);
        chk({tag, " outstanding"}, intf.outstanding, m_count());
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        bit          accept;
        int          stall;
        int          exp_id;
        bit          exp_kill;
        int          exp_out;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        vecs[0] = '{32'h0020F053, 32'd5,        32'd7,        1'b1, 0, 0, 1'b0, 1};
        vecs[1] = '{32'h00001053, 32'h11,       32'h22,       1'b0, 0, 1, 1'b1, 1};
        vecs[2] = '{32'h0A000053, 32'hDEADBEEF, 32'h12345678, 1'b1, 5, 2, 1'b0, 2};
        vecs[3] = '{32'h10000053, 32'd3,        32'd4,        1'b1, 1, 3, 1'b0, 3};
        vecs[4] = '{32'h20000053, 32'd9,        32'd9,        1'b0, 2, 4, 1'b1, 3};
        vecs[5] = '{32'h30000053, 32'd1,        32'd2,        1'b1, 0, 5, 1'b0, 4};

        intf.instr_valid = 0; intf.instr = '0; intf.rs1 = '0; intf.rs2 = '0;
        intf.issue_ready = 0; intf.issue_resp_accept = 0; intf.issue_resp_writeback = 0;
        intf.result_valid = 0; intf.result_id = '0; intf.result_data = '0;
        intf.result_rd = '0; intf.result_we = 0; intf.wb_stall = 0;
        m_reset();
        rst = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("reset issue/commit", {intf.issue_valid, intf.commit_valid, intf.commit_kill,
             intf.offload_done, intf.offload_rejected}, 0);
        chk("reset issue payload", {intf.issue_id, intf.issue_instr, intf.issue_rs0,
             intf.issue_rs1}, 0);
        chk("reset xreg", {intf.xreg_we, intf.xreg_waddr, intf.xreg_wdata}, 0);
        chk("reset status", {intf.outstanding, intf.protocol_err}, 0);
        chk("reset readies", {intf.instr_ready, intf.result_ready}, 0);
        tick(); tick();
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            do_issue(vecs[i].instr, vecs[i].rs1, vecs[i].rs2, vecs[i].accept, vecs[i].stall,
                     vecs[i].exp_id, vecs[i].exp_kill, vecs[i].exp_out, $sformatf("vec%0d", i));
            if (vecs[i].accept) tracked[vecs[i].exp_id] = 1'b1;
            m_next = (vecs[i].exp_id + 1) % 16;
        end

        chk("full instr_ready", intf.instr_ready, 0);
        chk("full outstanding", intf.outstanding, 4);
        send_result(2, 1'b1, 5'd10, 32'h40490FDB, 1'b0, "res id2");
        chk("res id2 out", intf.outstanding, 3);
        chk("res id2 instr_ready", intf.instr_ready, 1);
        tick();
        chk("xreg_we one pulse", intf.xreg_we, 0);

        send_result(9, 1'b1, 5'd3, 32'h12345678, 1'b0, "untracked");
        chk("untracked err", intf.protocol_err, 1);
        tick(); tick();
        chk("err sticky", intf.protocol_err, 1);
        send_result(0, 1'b1, 5'd4, 32'hCAFE0000, 1'b1, "wb_stall");
        chk("wb_stall out", intf.outstanding, 3);

        // Abort an issue in flight with an asynchronous reset between clock edges.
        intf.instr_valid = 1'b1;
        intf.instr       = 32'h00000053;
        tick();
        intf.instr_valid = 1'b0;
        chk("pre-abort issue_valid", intf.issue_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("abort issue_valid", intf.issue_valid, 0);
        chk("abort status", {intf.commit_valid, intf.outstanding, intf.protocol_err}, 0);
        tick(); tick();
        rst = 1'b0;
        m_reset();
        chk("post-reset outstanding", intf.outstanding, 0);
        do_issue(32'h0040F053, 32'd1, 32'd2, 1'b1, 0, 0, 1'b0, 1, "post-reset");
        tracked[0] = 1'b1;
        m_next = 1;

        for (int it = 0; it < 80; it++) begin
            chk("rnd instr_ready", intf.instr_ready, m_ready());
            if (m_ready() && ($urandom_range(0, 2) != 0 || m_count() == 0)) begin
                bit acc;
                int id;
                acc = ($urandom_range(0, 3) != 0);
                id  = m_next;
                do_issue($urandom, $urandom, $urandom, acc, $urandom_range(0, 2), id, !acc,
                         m_count() + int'(acc), "rnd issue");
                if (acc) tracked[id] = 1'b1;
                m_next = (m_next + 1) % 16;
            end else begin
                int id;
                id = $urandom_range(0, 15);
                if ($urandom_range(0, 9) != 0 && m_count() > 0) begin
                    while (!tracked[id]) id = (id + 1) % 16;
                end
                send_result(id, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                            ($urandom_range(0, 4) == 0), "rnd result");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/xif_offload_initiator.md
Name: xif_offload_initiator

Overview:
Core-side initiator of the CORE-V-XIF offload protocol used by rvfpm. It accepts instructions from the core pipeline and drives the issue handshake with freshly allocated IDs. It then drives the commit transaction and tracks outstanding accepted instructions. It also consumes result transactions and writes results back to the integer register file.

Parameters:
X_ID_WIDTH, 4, width of transaction ID; IDs wrap modulo 2^X_ID_WIDTH
XLEN, 32, integer operand/result width
MAX_OUTSTANDING, 4, max accepted-but-unresulted instructions (1..2^X_ID_WIDTH)

Ports:
ck  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous reset, active-high
instr_valid  in  1  core presents instruction
instr_ready  out  1  initiator takes instruction
instr  in  32  instruction word
rs1  in  XLEN  operand 0
rs2  in  XLEN  operand 1
issue_valid  out  1  XIF issue request valid
issue_ready  in  1  coprocessor ready
issue_instr  out  32  XIF issue_req.instr
issue_id  out  X_ID_WIDTH  XIF issue_req.id
issue_rs0  out  XLEN  XIF issue_req.rs[0]
issue_rs1  out  XLEN  XIF issue_req.rs[1]
issue_resp_accept  in  1  issue_resp.accept, sampled at issue handshake
issue_resp_writeback  in  1  issue_resp.writeback, sampled at issue handshake
commit_valid  out  1  XIF commit valid
commit_id  out  X_ID_WIDTH  commit.id
commit_kill  out  1  commit.commit_kill
result_valid  in  1  XIF result valid
result_ready  out  1  initiator accepts result
result_id  in  X_ID_WIDTH  result.id
result_data  in  XLEN  result.data
result_rd  in  5  result.rd
result_we  in  1  result.we
wb_stall  in  1  core writeback port busy
xreg_we  out  1  integer RF write enable
xreg_waddr  out  5  integer RF address
xreg_wdata  out  XLEN  integer RF data
offload_done  out  1  one-cycle pulse, instruction accepted and committed
offload_rejected  out  1  one-cycle pulse, coprocessor rejected instruction
outstanding  out  $clog2(MAX_OUTSTANDING+1)  count of in-flight accepted IDs
protocol_err  out  1  sticky: result for untracked ID

Behaviour:
- Reset (async, rst=1):
  - State is IDLE; next_id=0; id bitmap cleared; outstanding=0; protocol_err=0.
  - All outputs are 0, including issue_* data, commit_*, xreg_*, and pulses.
- FSM states are IDLE, ISSUE and COMMIT.
- IDLE:
  - instr_ready = 1 iff outstanding < MAX_OUTSTANDING and bitmap[next_id]==0. This is combinational from registered state.
  - On instr_valid&&instr_ready, register instr, rs1, rs2 and next_id into issue_* and go to ISSUE.
  - issue_valid is high from the next cycle.
- ISSUE:
  - issue_valid=1 and all issue_* fields stay stable until issue_ready=1. Never deassert without a handshake.
  - On handshake, sample accept and writeback, increment next_id (wraps), and go to COMMIT.
- COMMIT (exactly one cycle):
  - commit_valid=1 and commit_id=issued id.
  - commit_kill = ~accept.
  - If accept: set bitmap[id]; pulse offload_done.
  - Else: pulse offload_rejected, with no tracking.
  - Return to IDLE. Back-to-back throughput is therefore one instruction per 3 cycles.
- Result channel:
  - result_ready = ~wb_stall.
  - On result_valid&&result_ready:
    - If bitmap[result_id]==1: clear the bit. If result_we, then next cycle xreg_we=1, xreg_waddr=result_rd, xreg_wdata=result_data for one cycle.
    - If bitmap[result_id]==0: set protocol_err (sticky until reset) and do not write back.
  - result_rd==0 with result_we=1 still pulses xreg_we; the RF ignores x0.
- outstanding = popcount-equivalent counter:
  - +1 on accepted commit.
  - -1 on valid result handshake.
  - Both events in the same cycle leave it unchanged.
  - It never exceeds MAX_OUTSTANDING and never underflows. An untracked result does not decrement it.
- A result for the ID being committed in the same cycle is untracked, giving protocol_err. The coprocessor must not return a result before commit.
- ID wrap: if bitmap[next_id] is still set, instr_ready stays low until that ID's result arrives.
- Reset asserted mid-ISSUE or mid-COMMIT aborts immediately with no commit emitted; the coprocessor is reset alongside.

Test Plan:
1. Reset, then instr 0x0020F053 with rs1=5, rs2=7; issue_ready=1, accept=1. Expect issue_valid at cycle+1 with id=0. Expect commit_valid, commit_id=0, kill=0 and offload_done at the next cycle; outstanding=1.
2. Rejection: accept=0 at handshake. Expect commit_kill=1, offload_rejected pulse, outstanding unchanged, next issue uses id=1.
3. Stall: issue_ready held 0 for 5 cycles. Expect issue_valid and all issue_* fields constant for 5 cycles; commit only after issue_ready=1.
4. Back-pressure: 4 accepted instructions, no results. Expect outstanding=4 and instr_ready=0. Then result id=2, we=1, rd=10, data=0x40490FDB. Expect xreg_we/waddr=10/wdata=0x40490FDB next cycle, outstanding=3, instr_ready=1.
5. Error: result_id=9 never issued. Expect protocol_err=1 (held), no xreg_we, outstanding unchanged. wb_stall=1 forces result_ready=0.
6. Async reset mid-ISSUE. Expect issue_valid=0 immediately without a clock edge. After release, the first issue uses id=0 and outstanding=0.
